// File: rtl/gpio_cfg_loader.sv
// gpio_cfg_loader: loads per-pad configuration words into the two GPIO pad
// control shift chains (area1/area2, shifted in parallel), then strobes a
// load so all pads apply their new settings together.
//
// Optional feature: define GPIO_CFG_AUTOLOAD_EN to start one load sequence
// automatically on the first cycle after reset is released.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start; outputs at rest
// S_CLR   | serial_resetn low for 2*CLK_DIV cycles, then latch first word
// S_SHIFT | one bit per 2*CLK_DIV cycles, farthest pad first, MSB first
// S_LOAD  | serial_load high for 2*CLK_DIV cycles, then done pulse
//
// NUM_PADS must be at least 2 so that cfg_idx has a non-zero width.
module gpio_cfg_loader #(
  parameter int NUM_PADS = 19,
  parameter int CFG_BITS = 13,
  parameter int CLK_DIV  = 4
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic [$clog2(NUM_PADS)-1:0] cfg_idx,
  input  logic [CFG_BITS-1:0]         cfg_data_1,
  input  logic [CFG_BITS-1:0]         cfg_data_2,
  output logic                        serial_clock,
  output logic                        serial_load,
  output logic                        serial_resetn,
  output logic                        serial_data_1,
  output logic                        serial_data_2
);

  localparam int IW = $clog2(NUM_PADS);
  localparam int BW = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
  localparam logic [IW-1:0] LAST_PAD = IW'(NUM_PADS - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(CFG_BITS - 1);
  localparam logic [7:0]    PH_INIT  = 8'(CLK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_CLR, S_SHIFT, S_LOAD} state_t;

  state_t              state_q;
  logic [7:0]          ph_q;
  logic                half_q;
  logic [BW-1:0]       bit_q;
  logic [IW-1:0]       pad_q;
  logic [IW-1:0]       idx_q;
  logic [CFG_BITS-1:0] sr1_q, sr2_q;
  logic                busy_q, done_q, sclk_q, load_q, resetn_q, sd1_q, sd2_q;

  logic                go_d;
  logic                half_end_d;
  logic [IW-1:0]       idx_dec_d;
  logic [CFG_BITS-1:0] sh1_d, sh2_d;

`ifdef GPIO_CFG_AUTOLOAD_EN
  logic auto_q;

  // One-shot request on the first cycle out of reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) auto_q <= 1'b1;
    else          auto_q <= 1'b0;
  end

  assign go_d = start | auto_q;
`else
  assign go_d = start;
`endif

  assign half_end_d = (ph_q == 8'd0) && half_q;
  assign idx_dec_d  = (idx_q == '0) ? '0 : idx_q - 1'b1;
  assign sh1_d      = sr1_q << 1;
  assign sh2_d      = sr2_q << 1;

  // Sequencer: phase/bit/pad counters, shift registers and registered outputs.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= S_IDLE;
      ph_q     <= 8'd0;
      half_q   <= 1'b0;
      bit_q    <= '0;
      pad_q    <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sclk_q   <= 1'b0;
      load_q   <= 1'b0;
      resetn_q <= 1'b1;
      sd1_q    <= 1'b0;
      sd2_q    <= 1'b0;
      // shift registers deliberately keep their contents
    end else begin
      done_q <= 1'b0;
      // every active state is built from half-periods of CLK_DIV cycles
      if (state_q != S_IDLE) begin
        if (ph_q != 8'd0) begin
          ph_q <= ph_q - 8'd1;
        end else begin
          ph_q   <= PH_INIT;
          half_q <= ~half_q;
        end
      end
      case (state_q)
        S_IDLE: begin
          if (go_d) begin
            state_q  <= S_CLR;
            busy_q   <= 1'b1;
            idx_q    <= LAST_PAD;
            resetn_q <= 1'b0;
            ph_q     <= PH_INIT;
            half_q   <= 1'b0;
          end
        end
        S_CLR: begin
          if (half_end_d) begin
            state_q  <= S_SHIFT;
            resetn_q <= 1'b1;
            sr1_q    <= cfg_data_1;
            sr2_q    <= cfg_data_2;
            sd1_q    <= cfg_data_1[CFG_BITS-1];
            sd2_q    <= cfg_data_2[CFG_BITS-1];
            pad_q    <= LAST_PAD;
            bit_q    <= '0;
            idx_q    <= idx_dec_d;
          end
        end
        S_SHIFT: begin
          if (ph_q == 8'd0 && !half_q) begin
            sclk_q <= 1'b1;
          end else if (half_end_d) begin
            sclk_q <= 1'b0;
            if (bit_q == LAST_BIT) begin
              bit_q <= '0;
              if (pad_q == '0) begin
                state_q <= S_LOAD;
                sd1_q   <= 1'b0;
                sd2_q   <= 1'b0;
                load_q  <= 1'b1;
              end else begin
                pad_q <= pad_q - 1'b1;
                sr1_q <= cfg_data_1;
                sr2_q <= cfg_data_2;
                sd1_q <= cfg_data_1[CFG_BITS-1];
                sd2_q <= cfg_data_2[CFG_BITS-1];
                idx_q <= idx_dec_d;
              end
            end else begin
              bit_q <= bit_q + 1'b1;
              sr1_q <= sh1_d;
              sr2_q <= sh2_d;
              sd1_q <= sh1_d[CFG_BITS-1];
              sd2_q <= sh2_d[CFG_BITS-1];
            end
          end
        end
        S_LOAD: begin
          if (half_end_d) begin
            state_q <= S_IDLE;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            idx_q   <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign cfg_idx       = idx_q;
  assign serial_clock  = sclk_q;
  assign serial_load   = load_q;
  assign serial_resetn = resetn_q;
  assign serial_data_1 = sd1_q;
  assign serial_data_2 = sd2_q;

endmodule

// File: tb/tb_gpio_cfg_loader.sv
// Bench for gpio_cfg_loader: two instances (CLK_DIV=2 and CLK_DIV=1) with
// NUM_PADS=2, CFG_BITS=4; expectations come from a per-cycle timing model.
// Build with GPIO_CFG_AUTOLOAD_EN defined to cover the automatic first run.
module tb_gpio_cfg_loader;

  localparam int NP = 2;
  localparam int CB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, sel;
  logic [3:0] mem1 [NP];
  logic [3:0] mem2 [NP];

  logic       busy_a, done_a, sclk_a, load_a, rstn_a, sd1_a, sd2_a;
  logic       busy_b, done_b, sclk_b, load_b, rstn_b, sd1_b, sd2_b;
  logic [0:0] idx_a, idx_b;
  logic [3:0] c1_a, c2_a, c1_b, c2_b;
  logic       start_a, start_b;

  assign c1_a = mem1[idx_a];
  assign c2_a = mem2[idx_a];
  assign c1_b = mem1[idx_b];
  assign c2_b = mem2[idx_b];
  assign start_a = start & ~sel;
  assign start_b = start & sel;

  gpio_cfg_loader #(.NUM_PADS(NP), .CFG_BITS(CB), .CLK_DIV(2)) u_dut_a (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start_a), .busy(busy_a), .done(done_a),
    .cfg_idx(idx_a), .cfg_data_1(c1_a), .cfg_data_2(c2_a),
    .serial_clock(sclk_a), .serial_load(load_a), .serial_resetn(rstn_a),
    .serial_data_1(sd1_a), .serial_data_2(sd2_a));

  gpio_cfg_loader #(.NUM_PADS(NP), .CFG_BITS(CB), .CLK_DIV(1)) u_dut_b (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .cfg_idx(idx_b), .cfg_data_1(c1_b), .cfg_data_2(c2_b),
    .serial_clock(sclk_b), .serial_load(load_b), .serial_resetn(rstn_b),
    .serial_data_1(sd1_b), .serial_data_2(sd2_b));

  logic       o_busy, o_done, o_sclk, o_load, o_rstn, o_sd1, o_sd2;
  logic [0:0] o_idx;
  assign o_busy = sel ? busy_b : busy_a;
  assign o_done = sel ? done_b : done_a;
  assign o_sclk = sel ? sclk_b : sclk_a;
  assign o_load = sel ? load_b : load_a;
  assign o_rstn = sel ? rstn_b : rstn_a;
  assign o_sd1  = sel ? sd1_b  : sd1_a;
  assign o_sd2  = sel ? sd2_b  : sd2_a;
  assign o_idx  = sel ? idx_b  : idx_a;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_rest(input string tag);
    chk({tag, "_a"}, 32'({busy_a, done_a, idx_a, sclk_a, load_a, rstn_a, sd1_a, sd2_a}), 32'h04);
    chk({tag, "_b"}, 32'({busy_b, done_b, idx_b, sclk_b, load_b, rstn_b, sd1_b, sd2_b}), 32'h04);
  endtask

  // Observes one whole sequence cycle by cycle against the timing model.
  // Entry: at a negedge; if do_start, a start pulse is issued first.
  task automatic run_seq(input string tag, input bit do_start, input int mid_start_at,
                         input bit b2b, output logic [7:0] g1, output logic [7:0] g2);
    int d, total, shift_end, k, r, rises, exp_idx, p, j;
    int e_sclk, e_rstn, e_load, e_idx, e_data, e_done;
    logic [7:0] e1, e2;
    logic prev_sclk, exp_sclk;
    d = sel ? 1 : 2;
    total = 4*d + 2*d*NP*CB;
    shift_end = 2*d + 2*d*NP*CB;
    e1 = {mem1[1], mem1[0]};
    e2 = {mem2[1], mem2[0]};
    g1 = '0; g2 = '0;
    k = 0; rises = 0; prev_sclk = 1'b0;
    e_sclk = 0; e_rstn = 0; e_load = 0; e_idx = 0; e_data = 0; e_done = 0;
    if (do_start) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    while (o_busy && k < 2000) begin
      k++;
      start = (k == mid_start_at);
      exp_sclk = (k > 2*d && k <= shift_end) && (((k - 2*d - 1) % (2*d)) >= d);
      if (o_sclk !== exp_sclk) e_sclk++;
      if (o_rstn !== (k > 2*d)) e_rstn++;
      if (o_load !== (k > total - 2*d)) e_load++;
      if (o_done !== 1'b0) e_done++;
      if (k <= 2*d) exp_idx = NP - 1;
      else if (k <= shift_end) begin
        j = (k - 2*d - 1) / (2*d*CB);
        p = NP - 1 - j;
        exp_idx = (p > 0) ? p - 1 : 0;
      end else exp_idx = 0;
      if (32'(o_idx) != 32'(exp_idx)) e_idx++;
      if (k > 2*d && k <= shift_end) begin
        r = (k - 2*d - 1) / (2*d);
        if (o_sd1 !== e1[7-r] || o_sd2 !== e2[7-r]) e_data++;
      end else if (k > shift_end) begin
        if (o_sd1 !== 1'b0 || o_sd2 !== 1'b0) e_data++;
      end
      if (o_sclk && !prev_sclk) begin
        g1 = {g1[6:0], o_sd1};
        g2 = {g2[6:0], o_sd2};
        rises++;
      end
      prev_sclk = o_sclk;
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, "_busy_len"}, 32'(k), 32'(total));
    chk({tag, "_rises"}, 32'(rises), 32'(NP*CB));
    chk({tag, "_stream1"}, 32'(g1), 32'(e1));
    chk({tag, "_stream2"}, 32'(g2), 32'(e2));
    chk({tag, "_sclk_wave"}, 32'(e_sclk), 0);
    chk({tag, "_resetn_wave"}, 32'(e_rstn), 0);
    chk({tag, "_load_wave"}, 32'(e_load), 0);
    chk({tag, "_idx_wave"}, 32'(e_idx), 0);
    chk({tag, "_data_wave"}, 32'(e_data), 0);
    chk({tag, "_done_early"}, 32'(e_done), 0);
    chk({tag, "_done_pulse"}, 32'({o_done, o_busy, o_load, o_sclk, o_idx}), 32'h10);
    if (b2b) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end else begin
      @(negedge clk);
      chk({tag, "_after"}, 32'({o_done, o_busy, o_load}), 0);
    end
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < NP; i++) begin
      mem1[i] = 4'($urandom);
      mem2[i] = 4'($urandom);
    end
  endtask

  // Reset while shifting the 4th bit; no load strobe may ever appear.
  task automatic run_abort(input string tag);
    int k, loads;
    logic [7:0] g1, g2;
    k = 0; loads = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (k < 16) begin
      if (o_load) loads++;
      k++;
      @(negedge clk);
    end
    chk({tag, "_busy_before"}, 32'(o_busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk_rest({tag, "_rstvals"});
    if (o_load) loads++;
    rst = 1'b0;
    @(negedge clk);
    if (o_load) loads++;
    chk({tag, "_no_load"}, 32'(loads), 0);
`ifdef GPIO_CFG_AUTOLOAD_EN
    run_seq({tag, "_auto"}, 1'b0, 0, 1'b0, g1, g2);
`else
    chk({tag, "_idle"}, 32'(o_busy), 0);
    run_seq({tag, "_rerun"}, 1'b1, 0, 1'b0, g1, g2);
`endif
  endtask

  initial begin
    logic [7:0] g1, g2;
    int seen;
    rst = 1'b1; start = 1'b0; sel = 1'b0;
    for (int i = 0; i < NP; i++) begin mem1[i] = '0; mem2[i] = '0; end
    repeat (3) @(negedge clk);
    chk_rest("reset");
    randomize_mem();
    rst = 1'b0;
    @(negedge clk);
`ifdef GPIO_CFG_AUTOLOAD_EN
    run_seq("autoload", 1'b0, 0, 1'b0, g1, g2);
`endif
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (o_busy || o_done) seen++;
      @(negedge clk);
    end
    chk("idle_no_start", 32'(seen), 0);

    mem1[1] = 4'hA; mem2[1] = 4'h5; mem1[0] = 4'h3; mem2[0] = 4'hC;
    run_seq("bitorder", 1'b1, 0, 1'b0, g1, g2);
    chk("bitorder_d1", 32'(g1), 32'h0000_00A3);
    chk("bitorder_d2", 32'(g2), 32'h0000_005C);

    for (int i = 0; i < 3; i++) begin
      randomize_mem();
      repeat ($urandom_range(0, 5)) @(negedge clk);
      run_seq("rand", 1'b1, 0, 1'b0, g1, g2);
    end

    randomize_mem();
    run_seq("busy_start", 1'b1, 20, 1'b0, g1, g2);

    randomize_mem();
    run_seq("b2b_first", 1'b1, 0, 1'b1, g1, g2);
    run_seq("b2b_second", 1'b0, 0, 1'b0, g1, g2);

    randomize_mem();
    run_abort("abort");

    sel = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      randomize_mem();
      run_seq("div1", 1'b1, 0, 1'b0, g1, g2);
    end
    randomize_mem();
    run_seq("div1_b2b", 1'b1, 7, 1'b1, g1, g2);
    run_seq("div1_b2b2", 1'b0, 0, 1'b0, g1, g2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1);
  end

endmodule

// File: doc/gpio_cfg_loader.md
Name: gpio_cfg_loader

Overview:
- Configuration sequencer for the user-project GPIO pad array.
- Fetches one configuration word per pad from the housekeeping register file.
- Serialises the words onto two daisy-chained pad-control shift chains: area1 and area2, shifted in parallel.
- After shifting, pulses a load strobe so every pad control block applies its new DM, input-disable, holdover, slow-slew, vtrip, ib-mode, analog and OE settings together.

Parameters:
- NUM_PADS, 19: pads per chain; both chains are the same length.
- CFG_BITS, 13: configuration word width per pad.
- CLK_DIV, 4: clock cycles per serial_clock half-period; legal range 1..255.

Ports:
- wb_clk_i  input  1  system clock
- wb_rst_i  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to run a full load sequence
- busy  output  1  sequence in progress
- done  output  1  one-cycle pulse when the sequence completes
- cfg_idx  output  $clog2(NUM_PADS)  index of the pad word to present next
- cfg_data_1  input  CFG_BITS  area1 word for pad cfg_idx; combinational read
- cfg_data_2  input  CFG_BITS  area2 word for pad cfg_idx; combinational read
- serial_clock  output  1  shift clock to both chains
- serial_load  output  1  apply strobe to both chains
- serial_resetn  output  1  active-low clear of both chains
- serial_data_1  output  1  area1 chain data
- serial_data_2  output  1  area2 chain data

Behaviour:
- Reset values: busy=0, done=0, cfg_idx=0, serial_clock=0, serial_load=0, serial_resetn=1, serial_data_1=0, serial_data_2=0.
- Reset has the same effect mid-sequence: FSM returns to IDLE, the chains keep their contents, and no load is issued.
- All outputs are registered. D denotes CLK_DIV. A phase counter counts D cycles; a bit counter counts 0..CFG_BITS-1; a pad counter counts NUM_PADS-1 down to 0.
- IDLE:
  - start=1 sampled at edge N → CLR.
  - From cycle N+1: busy=1, cfg_idx=NUM_PADS-1.
  - start while busy is ignored.
- CLR:
  - serial_resetn=0 for 2D cycles.
  - On the last edge of CLR, latch cfg_data_1/cfg_data_2 into the two shift registers, then → SHIFT.
- SHIFT:
  - Each bit lasts 2D cycles.
  - serial_data_* is driven with the word MSB at the start of the bit; serial_clock=0 for D cycles, then 1 for D cycles.
  - At the end of the bit, shift left by one.
  - The farthest pad is shifted first (pad NUM_PADS-1, MSB first). After NUM_PADS*CFG_BITS bits, pad 0's LSB is nearest the chain head.
  - At the end of a pad's last bit, latch the next word, unless the finished pad was pad 0; in that case → LOAD.
  - When a word is latched for pad p, cfg_idx becomes p-1 on the same edge; at p=0 it saturates at 0.
  - The source must hold cfg_data_* stable and matching cfg_idx from the change of cfg_idx until the next latch edge.
- LOAD:
  - serial_clock=0, serial_data_*=0, serial_load=1 for 2D cycles, then → IDLE.
  - On that transition edge: busy=0, done=1 for exactly one cycle, cfg_idx=0.
- Timing:
  - busy is high for exactly 4D + 2D·NUM_PADS·CFG_BITS cycles.
  - The done pulse coincides with the first busy=0 cycle.
  - start on the done cycle is accepted (back-to-back runs).
- Invariants:
  - serial_clock and serial_load are never high together.
  - serial_resetn is high everywhere outside CLR.

Optional Feature:
- Macro GPIO_CFG_AUTOLOAD_EN.
- Defined: the first cycle after wb_rst_i deasserts behaves as if start=1, so the pads receive their default configuration with no firmware action. Later runs still need start.
- Undefined: the block stays in IDLE until start is asserted.

Test Plan:
- Bench configuration: NUM_PADS=2, CFG_BITS=4, CLK_DIV=2.
- Basic run: start pulse at edge N → busy high for 40 cycles from N+1; done=1 only at N+41; serial_resetn low for cycles N+1..N+4; serial_load high for the final 4 busy cycles.
- Bit order: pad1 words 4'hA/4'h5, pad0 words 4'h3/4'hC → serial_data_1 at the 8 serial_clock rises is 1,0,1,0,0,0,1,1; serial_data_2 is 0,1,0,1,1,1,0,0; cfg_idx is 1 until the first latch, then 0.
- Start while busy: second start pulse mid-SHIFT → ignored; exactly 8 serial_clock rises and one done pulse. Start on the done cycle → a second run begins on the next cycle.
- Reset mid-SHIFT: wb_rst_i after the 3rd bit → next cycle all outputs at reset values; no serial_load pulse ever occurs; a subsequent start completes a normal 40-cycle run.
- CLK_DIV=1 corner: busy for 20 cycles; serial_clock toggles every cycle during SHIFT; no overlap of serial_clock with serial_load.
- GPIO_CFG_AUTOLOAD_EN defined: release reset with start held 0 → busy rises on the next cycle; one full sequence and one done pulse; then IDLE.
